// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Shared glyph constants, slot-phase type and widths for the
//            seven-segment scan driver.
// Revision : 1.0  initial release
// ============================================================================
package seg7_pkg;

    localparam int DIGIT_IDX_W = 2;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } slot_phase_t;

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg7_decoder
// Purpose  : Combinational BCD to active-low seven-segment glyph lookup;
//            non-decimal codes render as a dash.
// Revision : 1.0  initial release
// ============================================================================
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_digit)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule : seg7_decoder
`default_nettype wire

// File: rtl/seg7_scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_mux
// Purpose  : Four-digit common-anode 7-segment scanner with per-frame digit
//            snapshot and dead-time blanking between slots.
//            Option macro: SEG7_LEADING_ZERO_BLANK_EN (blank a zero in d3).
// Revision : 1.0  initial release
// ============================================================================
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 500
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] d3,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    input  logic [3:0] dp_in,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int               CNT_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] C_DEAD   = CNT_W'(DEAD_CYCLES);

    logic [CNT_W-1:0]       r_cnt;
    logic [DIGIT_IDX_W-1:0] r_idx;
    logic [3:0][3:0]        r_shadow;
    logic [3:0]             r_shadow_dp;
    logic [3:0]             r_an;
    logic [6:0]             r_seg;
    logic                   r_dp;
    logic                   r_frame_tick;

    logic                   w_wrap;
    logic                   w_snap;
    slot_phase_t            w_phase;
    logic [3:0]             w_digit;
    logic [6:0]             w_glyph;
    logic                   w_lz_blank;

    always_comb begin
        w_wrap  = (r_cnt == C_LAST);
        w_snap  = w_wrap && (r_idx == DIGIT_IDX_W'(3));
        w_phase = (r_cnt < C_DEAD) ? BLANK : SHOW;
        w_digit = r_shadow[r_idx];
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    assign w_lz_blank = (r_idx == DIGIT_IDX_W'(3)) && (r_shadow[3] == 4'd0);
`else
    assign w_lz_blank = 1'b0;
`endif

    seg7_decoder u_decoder (
        .i_digit (w_digit),
        .o_seg   (w_glyph)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
            r_idx <= r_idx + DIGIT_IDX_W'(1);
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Shadow copy is taken only at the very end of the last slot so a frame
    // never mixes digits from two different counter values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_shadow     <= '0;
            r_shadow_dp  <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_snap;
            if (w_snap) begin
                r_shadow    <= {d3, d2, d1, d0};
                r_shadow_dp <= dp_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_an  <= 4'b1111;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else if ((w_phase == SHOW) && !w_lz_blank) begin
            r_an  <= ~(4'b0001 << r_idx);
            r_seg <= w_glyph;
            r_dp  <= ~r_shadow_dp[r_idx];
        end else begin
            r_an  <= 4'b1111;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_tick = r_frame_tick;

endmodule : seg7_scan_mux
`default_nettype wire

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
Time-multiplexed driver for a common-anode 4-digit 7-segment display. It sits downstream of the MM.SS stopwatch counter and consumes its four BCD digit outputs (d3..d0). It snapshots the digits once per scan frame to avoid tearing, decodes them to segment patterns, and scans the anodes. A dead-time gap between digits suppresses ghosting.

Parameters:
REFRESH_DIV, 50000, clock cycles per digit slot (1 kHz per digit at 50 MHz); must be at least 2.
DEAD_CYCLES, 500, cycles at the start of each slot with all anodes off; must be less than REFRESH_DIV.

Ports:
clk  in  1  system clock.
reset_n  in  1  reset, synchronous, active-low.
d3  in  4  digit for the leftmost position (minutes tens).
d2  in  4  minutes ones.
d1  in  4  seconds tens.
d0  in  4  digit for the rightmost position (seconds ones).
dp_in  in  4  decimal point request per digit; bit i belongs to digit i; active-high.
an  out  4  anode enables, active-low; an[i] selects digit i.
seg  out  7  segment drive {g,f,e,d,c,b,a}, active-low.
dp  out  1  decimal point drive, active-low.
frame_tick  out  1  one-cycle pulse when a new digit snapshot is captured.

Behaviour:
- Clock and reset: one clock domain, clk. reset_n is synchronous and active-low.
- Reset (reset_n low at a clk edge) sets:
  - phase counter cnt = 0, digit index idx = 0;
  - shadow digits and shadow dp = 0;
  - an = 4'b1111, seg = 7'b1111111, dp = 1, frame_tick = 0.
  - A reset mid-scan takes effect on the next edge. The scan restarts at idx 0, cnt 0.
- Phase counter cnt:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - On wrap, idx advances 0→1→2→3→0.
- Slot phases, decided from the current cnt:
  - BLANK while cnt < DEAD_CYCLES;
  - SHOW while cnt ≥ DEAD_CYCLES.
- Snapshot:
  - When cnt == REFRESH_DIV-1 and idx == 3, all four digits and dp_in are captured into the shadow registers.
  - frame_tick is asserted for exactly that one cycle.
  - Input changes at any other time do not affect the display until the next snapshot.
  - Before the first snapshot, the display shows zeros.
- Outputs are registered. an, seg and dp at edge t+1 reflect cnt, idx and shadow values at t (one-cycle latency).
  - BLANK: an = 1111, seg = 1111111, dp = 1.
  - SHOW: an = ~(1 << idx), seg = glyph(shadow[idx]), dp = ~shadow_dp[idx].
- Glyphs (active-low, {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Values 10–15 display a dash, 0111111. No out-of-range error is flagged.
- Dead time: each slot has exactly DEAD_CYCLES all-off cycles at its start, including the first slot after reset.
- With DEAD_CYCLES = 0, there is no BLANK phase and anodes switch directly between digits.
- Duty: each digit is lit for (REFRESH_DIV-DEAD_CYCLES) of every 4·REFRESH_DIV cycles.

Optional Feature:
Macro SEG7_LEADING_ZERO_BLANK_EN.
- Defined: when shadow d3 == 0, slot 3 stays fully blank for its whole duration (an = 1111, seg = 1111111, dp = 1), so "05:30" shows as " 5:30". Slot timing and idx sequence are unchanged.
- Undefined: all four digits are always shown, including a leading zero.

Decomposition:
- Package seg7_pkg:
  - glyph constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK;
  - slot-phase enum {BLANK, SHOW};
  - digit-index width constant (2).
- Sub-module seg7_decoder: purely combinational 4-bit to 7-bit active-low glyph lookup, instantiated once on the muxed shadow digit.
- Counter, snapshot, scan and output registers stay in seg7_scan_mux.

Test Plan:
All scenarios use REFRESH_DIV=8, DEAD_CYCLES=2.
1. Reset: hold reset_n low for 3 cycles during an active scan → an=1111, seg=1111111, dp=1, frame_tick=0 after the first edge. After release, the first lit cycle has an=1110.
2. Apply d3..d0=1,2,3,4 and wait for the first frame_tick → in slot idx 0, the SHOW cycles show an=1110, seg=0011001. In slot idx 3 they show an=0111, seg=1111001.
3. Tearing: change d0 from 4 to 7 mid-frame → seg for idx 0 stays 0011001 until after the next frame_tick, then becomes 1111000. frame_tick occurs every 32 cycles.
4. Dead time: at every slot boundary, an=1111 for exactly 2 consecutive cycles, followed by exactly 6 cycles with one anode low. dp_in=4'b0100 gives dp=0 only during idx 2 SHOW cycles.
5. Out-of-range: d1=12 → seg=0111111 during idx 1 SHOW. With SEG7_LEADING_ZERO_BLANK_EN and d3=0, idx 3 shows an=1111 for all 8 cycles.
6. Reset mid-scan at idx 2, cnt 5 → next edge all-off, and scanning resumes at idx 0 with the shadow digits zeroed (seg=1000000).
